// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: timed green/yellow/clear head sequencer fed by traffic_controller; TRAFFIC_PED_EN adds a pedestrian walk.
module traffic_phase_sequencer #(
   parameter int GREEN_MIN = 8,
   parameter int YELLOW_CYC = 3,
   parameter int CLEAR_CYC = 2,
`ifdef TRAFFIC_PED_EN
   parameter int WALK_CYC = 6,
`endif
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] next_state,
   input  logic       req_valid,
`ifdef TRAFFIC_PED_EN
   input  logic       ped_req,
   output logic       ped_walk,
`endif
   output logic       req_ready,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       cur_state,
   output logic       prev_state,
   output logic       phase_change,
   output logic       err
);
   typedef enum logic [1:0] {GREEN, YELLOW, CLEAR, RED_HOLD} state_t;
   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
   localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
   localparam logic [CNT_W-1:0] Y_END = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] C_END = CNT_W'(CLEAR_CYC - 1);
   state_t state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0] tgt_q, tgt_d;
   logic [2:0] ns_q, ns_d, ew_q, ew_d;
   logic cur_q, cur_d, prev_q, prev_d, rdy_q, rdy_d, pc_q, pc_d, err_q, err_d;
   logic acc, clr_done, enter_g, axis;
`ifdef TRAFFIC_PED_EN
   localparam logic [CNT_W-1:0] W_END = CNT_W'(CLEAR_CYC + WALK_CYC - 1);
   logic pend_q, pend_d, walk_q, walk_d;
`endif
   always_comb begin
      acc = req_valid && rdy_q;
      state_d = state_q;
      tgt_d = tgt_q;
      enter_g = 1'b0;
      axis = tgt_q[0];
      err_d = err_q | (acc && next_state[2]);
`ifdef TRAFFIC_PED_EN
      pend_d = pend_q | ped_req;
      walk_d = walk_q;
      clr_done = walk_q ? timer_q == W_END : timer_q == C_END && !pend_q;
      // a pending request stretches this clearance; requests during the walk carry to the next one
      if (state_q == CLEAR && !walk_q && timer_q == C_END && pend_q) begin
         walk_d = 1'b1;
         pend_d = ped_req;
      end
      if (state_q == CLEAR && clr_done) walk_d = 1'b0;
`else
      clr_done = timer_q == C_END;
`endif
      case (state_q)
         GREEN: if (acc && (next_state == 3'd3 || (next_state == 3'd1 && cur_q) || (next_state == 3'd2 && !cur_q))) begin
            state_d = YELLOW;
            tgt_d = {next_state == 3'd3, next_state == 3'd2};
         end
         YELLOW: if (timer_q == Y_END) state_d = CLEAR;
         CLEAR: if (clr_done) begin
            state_d = tgt_q[1] ? RED_HOLD : GREEN;
            enter_g = !tgt_q[1];
         end
         default: if (acc && (next_state == 3'd1 || next_state == 3'd2)) begin
            state_d = GREEN;
            enter_g = 1'b1;
            axis = next_state[1];
         end
      endcase
      timer_d = state_d != state_q ? '0 : timer_q == '1 ? timer_q : timer_q + 1'b1;
      cur_d = enter_g ? axis : cur_q;
      prev_d = enter_g ? cur_q : prev_q;
      pc_d = enter_g;
      rdy_d = state_d == RED_HOLD || (state_d == GREEN && timer_d >= G_MIN);
      ns_d = !cur_d && state_d == GREEN ? G : !cur_d && state_d == YELLOW ? Y : R;
      ew_d = cur_d && state_d == GREEN ? G : cur_d && state_d == YELLOW ? Y : R;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         tgt_q <= '0;
         timer_q <= '0;
         cur_q <= 1'b0;
         prev_q <= 1'b0;
         rdy_q <= 1'b0;
         pc_q <= 1'b0;
         err_q <= 1'b0;
         ns_q <= R;
         ew_q <= R;
`ifdef TRAFFIC_PED_EN
         pend_q <= 1'b0;
         walk_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tgt_q <= tgt_d;
         timer_q <= timer_d;
         cur_q <= cur_d;
         prev_q <= prev_d;
         rdy_q <= rdy_d;
         pc_q <= pc_d;
         err_q <= err_d;
         ns_q <= ns_d;
         ew_q <= ew_d;
`ifdef TRAFFIC_PED_EN
         pend_q <= pend_d;
         walk_q <= walk_d;
`endif
      end
   end
   assign req_ready = rdy_q;
   assign ns_light = ns_q;
   assign ew_light = ew_q;
   assign cur_state = cur_q;
   assign prev_state = prev_q;
   assign phase_change = pc_q;
   assign err = err_q;
`ifdef TRAFFIC_PED_EN
   assign ped_walk = walk_q;
`endif
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: scoreboard bench; per-cycle expected head/handshake values queued, popped by a monitor.
module tb_traffic_phase_sequencer;
   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
   typedef struct packed {
      logic [2:0] ns;
      logic [2:0] ew;
      logic rdy, cur, prv, pc, er, wk;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
   logic [2:0] next_state = 3'd0;
   logic req_ready, cur_state, prev_state, phase_change, err, walk_sig;
   logic [2:0] ns_light, ew_light;
   exp_t q[$];
   exp_t e, got;
   int checks = 0, errors = 0, mon_cyc = 0, now_c = 0;
   logic mon_on = 1'b0;
`ifdef TRAFFIC_PED_EN
   logic ped_req = 1'b0, ped_walk;
   assign walk_sig = ped_walk;
`else
   assign walk_sig = 1'b0;
`endif
   traffic_phase_sequencer dut (
      .clk(clk), .rst(rst), .next_state(next_state), .req_valid(req_valid),
`ifdef TRAFFIC_PED_EN
      .ped_req(ped_req), .ped_walk(ped_walk),
`endif
      .req_ready(req_ready), .ns_light(ns_light), .ew_light(ew_light), .cur_state(cur_state),
      .prev_state(prev_state), .phase_change(phase_change), .err(err)
   );
   always #5 clk = ~clk;
   task automatic ex(input int n, input logic [2:0] ns, input logic [2:0] ew, input logic rdy, input logic cur,
                     input logic prv, input logic pc, input logic er, input logic wk = 1'b0);
      for (int i = 0; i < n; i++) q.push_back('{ns, ew, rdy, cur, prv, pc, er, wk});
   endtask
   task automatic go(input int c);
      while (now_c < c) begin
         @(posedge clk);
         #1;
         now_c++;
      end
   endtask
   always @(negedge clk) begin
      if (mon_on && q.size() != 0) begin
         e = q.pop_front();
         got = '{ns_light, ew_light, req_ready, cur_state, prev_state, phase_change, err, walk_sig};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL cycle %0d: got ns=%b ew=%b rdy=%b cur=%b prev=%b pc=%b err=%b walk=%b, required ns=%b ew=%b rdy=%b cur=%b prev=%b pc=%b err=%b walk=%b",
                     mon_cyc, got.ns, got.ew, got.rdy, got.cur, got.prv, got.pc, got.er, got.wk,
                     e.ns, e.ew, e.rdy, e.cur, e.prv, e.pc, e.er, e.wk);
         end
         mon_cyc++;
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      ex(2, R, R, 0, 0, 0, 0, 0);
      ex(1, G, R, 0, 0, 0, 1, 0);
      ex(7, G, R, 0, 0, 0, 0, 0);
      ex(1, G, R, 1, 0, 0, 0, 0);
      ex(3, Y, R, 0, 0, 0, 0, 0);
      ex(2, R, R, 0, 0, 0, 0, 0);
      ex(1, R, G, 0, 1, 0, 1, 0);
      ex(7, R, G, 0, 1, 0, 0, 0);
      ex(1, R, G, 1, 1, 0, 0, 0);
      ex(2, R, G, 1, 1, 0, 0, 1);
      ex(3, R, Y, 0, 1, 0, 0, 1);
      ex(2, R, R, 0, 1, 0, 0, 1);
      ex(1, G, R, 0, 0, 1, 1, 1);
      ex(7, G, R, 0, 0, 1, 0, 1);
      ex(3, G, R, 1, 0, 1, 0, 1);
      ex(3, Y, R, 0, 0, 1, 0, 1);
      ex(2, R, R, 0, 0, 1, 0, 1);
      ex(2, R, R, 1, 0, 1, 0, 1);
      ex(1, G, R, 0, 0, 0, 1, 1);
      ex(7, G, R, 0, 0, 0, 0, 1);
      ex(1, G, R, 1, 0, 0, 0, 1);
      ex(2, Y, R, 0, 0, 0, 0, 1);
      ex(2, R, R, 0, 0, 0, 0, 0);
      ex(1, G, R, 0, 0, 0, 1, 0);
      ex(7, G, R, 0, 0, 0, 0, 0);
      ex(1, G, R, 1, 0, 0, 0, 0);
      ex(3, Y, R, 0, 0, 0, 0, 0);
      ex(2, R, R, 0, 0, 0, 0, 0);
`ifdef TRAFFIC_PED_EN
      ex(6, R, R, 0, 0, 0, 0, 0, 1);
`endif
      ex(1, R, G, 0, 1, 0, 1, 0);
      mon_on = 1'b1;
      go(5);  next_state = 3'd2; req_valid = 1'b1;
      go(11); req_valid = 1'b0;
      go(24); next_state = 3'd6; req_valid = 1'b1;
      go(25); next_state = 3'd2;
      go(26); next_state = 3'd1;
      go(27); req_valid = 1'b0;
      go(40); next_state = 3'd1; req_valid = 1'b1;
      go(41); next_state = 3'd0;
      go(42); next_state = 3'd3;
      go(43); req_valid = 1'b0;
      go(48); next_state = 3'd0; req_valid = 1'b1;
      go(49); next_state = 3'd1;
      go(50); req_valid = 1'b0;
      go(58); next_state = 3'd2; req_valid = 1'b1;
      go(59); req_valid = 1'b0;
      go(60); rst = 1'b1;
      go(61); rst = 1'b0;
`ifdef TRAFFIC_PED_EN
      go(64); ped_req = 1'b1;
      go(65); ped_req = 1'b0;
`endif
      go(71); next_state = 3'd2; req_valid = 1'b1;
      go(72); req_valid = 1'b0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
